// File: rtl/eeg_pea_eng_feeder.sv
// PE data-in stream initiator: fetches activations from ARAM and pairs each one
// with the non-skipped weights of a small register file, one beat per weight.
module eeg_pea_eng_feeder #(
    parameter int DATA_ACT_DW = 8,
    parameter int DATA_WEI_DW = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int CONV_WEI_DW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   START,
    output logic                   BUSY,
    output logic                   DONE,
    input  logic [ARAM_ADD_AW-1:0] CFG_ACT_BASE,
    input  logic [ARAM_ADD_AW:0]   CFG_ACT_LEN,
    input  logic [CONV_WEI_DW-1:0] CFG_WEI_LEN,
    input  logic                   CFG_SKIP_ZERO,
    input  logic                   WEI_WEN,
    input  logic [CONV_WEI_DW-1:0] WEI_WADD,
    input  logic [DATA_WEI_DW-1:0] WEI_WDAT,
    output logic                   ARAM_REN,
    output logic [ARAM_ADD_AW-1:0] ARAM_RADD,
    input  logic [DATA_ACT_DW-1:0] ARAM_RDAT,
    output logic                   DIN_VLD,
    input  logic                   DIN_RDY,
    output logic                   ACT_LST,
    output logic                   WEI_LST,
    output logic [DATA_ACT_DW-1:0] ACT_DAT,
    output logic [ARAM_ADD_AW-1:0] ACT_ADD,
    output logic [DATA_WEI_DW-1:0] WEI_DAT,
    output logic [CONV_WEI_DW-1:0] WEI_IDX
);
    localparam int NW = 1 << CONV_WEI_DW;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [DATA_WEI_DW-1:0] wfile [NW];
    logic [ARAM_ADD_AW-1:0] base_r;
    logic [ARAM_ADD_AW-1:0] act_cnt;
    logic [ARAM_ADD_AW:0]   len_m1;
    logic [NW-1:0]          mask_r, mask_new;
    logic [CONV_WEI_DW-1:0] last_r, last_new;
    logic [CONV_WEI_DW-1:0] wei_cnt, wei_nxt;
    logic [CONV_WEI_DW-1:0] wlen_eff;
    logic [DATA_ACT_DW-1:0] act_reg;
    logic                   start_ok, hs, wei_last, act_last;

    assign start_ok = (state == S_IDLE) && START;
    assign hs       = (state == S_EMIT) && DIN_RDY;
    assign wei_last = (wei_cnt == last_r);
    assign act_last = ({1'b0, act_cnt} == len_m1);
    assign wlen_eff = (CFG_WEI_LEN == '0) ? CONV_WEI_DW'(1) : CFG_WEI_LEN;

    // Emission mask is frozen at START; index 0 is always emitted so every
    // activation produces at least one beat.
    always_comb begin
        mask_new = '0;
        last_new = '0;
        for (int k = 0; k < NW; k++) begin
            mask_new[k] = (k < int'(wlen_eff)) &&
                          ((k == 0) || !CFG_SKIP_ZERO || (wfile[k] != '0));
            if (mask_new[k]) last_new = CONV_WEI_DW'(k);
        end
    end

    // Next emitted index: lowest set mask bit above the current one.
    always_comb begin
        wei_nxt = wei_cnt;
        for (int k = NW - 1; k >= 0; k--) begin
            if (mask_r[k] && (CONV_WEI_DW'(k) > wei_cnt)) wei_nxt = CONV_WEI_DW'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        BUSY      = (state != S_IDLE);
        DONE      = 1'b0;
        ARAM_REN  = 1'b0;
        ARAM_RADD = '0;
        DIN_VLD   = 1'b0;
        ACT_LST   = 1'b0;
        WEI_LST   = 1'b0;
        ACT_DAT   = '0;
        ACT_ADD   = '0;
        WEI_DAT   = '0;
        WEI_IDX   = '0;
        case (state)
            S_IDLE: begin
                if (START) state_nxt = (CFG_ACT_LEN == '0) ? S_DONE : S_RD;
            end
            S_RD: begin
                ARAM_REN  = 1'b1;
                ARAM_RADD = base_r + act_cnt;
                state_nxt = S_WAIT;
            end
            S_WAIT: state_nxt = S_EMIT;
            S_EMIT: begin
                DIN_VLD = 1'b1;
                ACT_DAT = act_reg;
                ACT_ADD = act_cnt;
                WEI_DAT = wfile[wei_cnt];
                WEI_IDX = wei_cnt;
                WEI_LST = wei_last;
                ACT_LST = act_last;
                if (hs && wei_last) state_nxt = act_last ? S_DONE : S_RD;
            end
            S_DONE: begin
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r  <= '0;
            len_m1  <= '0;
            mask_r  <= '0;
            last_r  <= '0;
            act_cnt <= '0;
            wei_cnt <= '0;
            act_reg <= '0;
        end else begin
            if (start_ok) begin
                base_r  <= CFG_ACT_BASE;
                len_m1  <= CFG_ACT_LEN - 1'b1;
                mask_r  <= mask_new;
                last_r  <= last_new;
                act_cnt <= '0;
            end
            if (state == S_WAIT) begin
                act_reg <= ARAM_RDAT;
                wei_cnt <= '0;
            end
            if (hs) begin
                if (!wei_last)      wei_cnt <= wei_nxt;
                else if (!act_last) act_cnt <= act_cnt + 1'b1;
            end
        end
    end

    // The weight file is only writable while idle, so a running stream never
    // sees its weights change underneath it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) wfile[k] <= '0;
        end else if ((state == S_IDLE) && WEI_WEN) begin
            wfile[WEI_WADD] <= WEI_WDAT;
        end
    end

endmodule

// File: tb/tb_eeg_pea_eng_feeder.sv
// Self-checking bench for eeg_pea_eng_feeder: a queue-based beat model predicts
// every cycle's outputs; fixed scenarios also pin the beat stream to literals.
module tb_eeg_pea_eng_feeder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       START = 1'b0;
    logic       BUSY, DONE;
    logic [9:0] CFG_ACT_BASE = '0;
    logic [10:0] CFG_ACT_LEN = '0;
    logic [2:0] CFG_WEI_LEN = '0;
    logic       CFG_SKIP_ZERO = 1'b0;
    logic       WEI_WEN = 1'b0;
    logic [2:0] WEI_WADD = '0;
    logic [7:0] WEI_WDAT = '0;
    logic       ARAM_REN;
    logic [9:0] ARAM_RADD;
    logic [7:0] ARAM_RDAT = '0;
    logic       DIN_VLD;
    logic       DIN_RDY = 1'b1;
    logic       ACT_LST, WEI_LST;
    logic [7:0] ACT_DAT;
    logic [9:0] ACT_ADD;
    logic [7:0] WEI_DAT;
    logic [2:0] WEI_IDX;

    always #5 clk = ~clk;

    eeg_pea_eng_feeder dut (
        .clk(clk), .rst_n(rst_n), .START(START), .BUSY(BUSY), .DONE(DONE),
        .CFG_ACT_BASE(CFG_ACT_BASE), .CFG_ACT_LEN(CFG_ACT_LEN),
        .CFG_WEI_LEN(CFG_WEI_LEN), .CFG_SKIP_ZERO(CFG_SKIP_ZERO),
        .WEI_WEN(WEI_WEN), .WEI_WADD(WEI_WADD), .WEI_WDAT(WEI_WDAT),
        .ARAM_REN(ARAM_REN), .ARAM_RADD(ARAM_RADD), .ARAM_RDAT(ARAM_RDAT),
        .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY), .ACT_LST(ACT_LST), .WEI_LST(WEI_LST),
        .ACT_DAT(ACT_DAT), .ACT_ADD(ACT_ADD), .WEI_DAT(WEI_DAT), .WEI_IDX(WEI_IDX)
    );

    logic [7:0] aram [1024];
    always @(posedge clk) if (ARAM_REN) ARAM_RDAT <= aram[ARAM_RADD];

    typedef struct {
        logic [7:0] act; logic [9:0] add; logic [7:0] wei; logic [2:0] idx; logic wl; logic al;
    } beat_t;

    beat_t      q[$];
    beat_t      pin_q[$];
    logic [7:0] mw [8];
    logic       m_busy = 1'b0, m_done = 1'b0;
    int         gap = 0;
    logic [9:0] m_base = '0;
    int         vectors = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [30:0] pack(input beat_t b);
        return {b.al, b.wl, b.act, b.add, b.wei, b.idx};
    endfunction

    // Model: one pass computes the whole beat list at START; the cycle timing
    // is "2 idle cycles (read, wait) before each activation's beats".
    always @(negedge clk) begin
        beat_t b, p;
        logic  exp_vld, hs, busy_now, nxt_done;
        logic [9:0] exp_radd;
        logic [7:0] nz;
        int wl, last, len;
        if (!rst_n) begin
            chk("reset_outputs", 64'({BUSY, DONE, ARAM_REN, ARAM_RADD, DIN_VLD, ACT_LST,
                                      WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX}), 64'(0));
            q.delete();
            m_busy = 1'b0; m_done = 1'b0; gap = 0;
            for (int k = 0; k < 8; k++) mw[k] = '0;
        end else begin
            exp_vld = m_busy && (gap == 0) && (q.size() > 0);
            chk("busy", 64'(BUSY), 64'(m_busy));
            chk("done", 64'(DONE), 64'(m_done));
            chk("din_vld", 64'(DIN_VLD), 64'(exp_vld));
            chk("aram_ren", 64'(ARAM_REN), 64'(gap == 2));
            exp_radd = (gap == 2) ? 10'(m_base + q[0].add) : 10'(0);
            chk("aram_radd", 64'(ARAM_RADD), 64'(exp_radd));
            b = '{default: '0};
            if (exp_vld) b = q[0];
            chk("beat", 64'({ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX}), 64'(pack(b)));
            hs = exp_vld && DIN_RDY;
            if (hs && pin_q.size() > 0) begin
                p = pin_q.pop_front();
                chk("pinned_beat", 64'({ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX}),
                    64'(pack(p)));
            end
            busy_now = m_busy;
            nxt_done = 1'b0;
            if (m_done) m_busy = 1'b0;
            if (gap > 0) gap--;
            else if (hs) begin
                b = q.pop_front();
                if (b.wl) begin
                    if (b.al) nxt_done = 1'b1;
                    else      gap = 2;
                end
            end
            if (START && !busy_now) begin
                wl = (CFG_WEI_LEN == 0) ? 1 : int'(CFG_WEI_LEN);
                len = int'(CFG_ACT_LEN);
                last = 0;
                for (int k = 0; k < 8; k++) begin
                    nz[k] = (k < wl) && (k == 0 || !CFG_SKIP_ZERO || mw[k] != 0);
                    if (nz[k]) last = k;
                end
                m_base = CFG_ACT_BASE;
                for (int i = 0; i < len; i++)
                    for (int k = 0; k < 8; k++)
                        if (nz[k]) q.push_back('{aram[10'(int'(CFG_ACT_BASE) + i)], 10'(i),
                                                 mw[k], 3'(k), k == last, i == len - 1});
                m_busy = 1'b1;
                if (len == 0) nxt_done = 1'b1;
                else          gap = 2;
            end
            if (WEI_WEN && !busy_now) mw[WEI_WADD] = WEI_WDAT;
            m_done = nxt_done;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr_w(input int a, input int d);
        WEI_WEN = 1'b1; WEI_WADD = 3'(a); WEI_WDAT = 8'(d);
        tick();
        WEI_WEN = 1'b0;
    endtask

    task automatic load_w(input int w0, input int w1, input int w2);
        wr_w(0, w0); wr_w(1, w1); wr_w(2, w2);
    endtask

    task automatic pin(input int act, input int add, input int wei, input int idx,
                       input int wl, input int al);
        pin_q.push_back('{8'(act), 10'(add), 8'(wei), 3'(idx), wl != 0, al != 0});
    endtask

    task automatic pin_scen1();
        pin(5, 0, 3, 0, 0, 0); pin(5, 0, 8'hFE, 2, 1, 0);
        pin(8'hFF, 1, 3, 0, 0, 1); pin(8'hFF, 1, 8'hFE, 2, 1, 1);
    endtask

    // mode 0: full ready; 1: random ready plus junk START/WEI_WEN while busy;
    // 2: ready low cycles 4-6 (stalls the second beat); 3: reset at cycle 4.
    task automatic run(input int base, input int len, input int wlen, input int skip, input int mode);
        int cyc;
        CFG_ACT_BASE = 10'(base); CFG_ACT_LEN = 11'(len);
        CFG_WEI_LEN = 3'(wlen); CFG_SKIP_ZERO = (skip != 0);
        DIN_RDY = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        cyc = 1;
        while (m_busy) begin
            if (cyc > 3000) begin
                $display("FAIL run_timeout: still busy after %0d cycles, expected idle", cyc);
                $fatal(1);
            end
            case (mode)
                1: begin
                    DIN_RDY  = ($urandom_range(0, 2) != 0);
                    START    = ($urandom_range(0, 3) == 0);
                    WEI_WEN  = ($urandom_range(0, 3) == 0);
                    WEI_WADD = 3'($urandom);
                    WEI_WDAT = 8'($urandom);
                end
                2: DIN_RDY = !(cyc >= 4 && cyc <= 6);
                3: if (cyc == 4) rst_n = 1'b0;
                default: DIN_RDY = 1'b1;
            endcase
            tick();
            cyc++;
        end
        START = 1'b0; WEI_WEN = 1'b0; DIN_RDY = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) aram[i] = 8'($urandom);
        aram[4] = 8'd5; aram[5] = 8'hFF;
        for (int k = 0; k < 8; k++) mw[k] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        load_w(3, 0, 8'hFE);
        pin_scen1();
        run(4, 2, 3, 1, 0);

        pin(5, 0, 3, 0, 0, 0); pin(5, 0, 0, 1, 0, 0); pin(5, 0, 8'hFE, 2, 1, 0);
        pin(8'hFF, 1, 3, 0, 0, 1); pin(8'hFF, 1, 0, 1, 0, 1); pin(8'hFF, 1, 8'hFE, 2, 1, 1);
        run(4, 2, 3, 0, 0);

        pin_scen1();
        run(4, 2, 3, 1, 2);

        run(4, 0, 3, 1, 0);
        for (int k = 0; k < 8; k++) wr_w(k, 0);
        pin(5, 0, 0, 0, 1, 1);
        run(4, 1, 5, 1, 0);

        load_w(3, 0, 8'hFE);
        run(4, 2, 3, 1, 3);
        pin_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        load_w(3, 0, 8'hFE);
        pin_scen1();
        run(4, 2, 3, 1, 0);

        load_w(3, 0, 8'hFE);
        pin_scen1();
        run(4, 2, 3, 1, 1);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 8; k++)
                wr_w(k, ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 255)));
            run((r % 5 == 0) ? 1022 : int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 1)), (r % 3 == 0) ? 0 : 1);
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/eeg_pea_eng_feeder.md
Name: eeg_pea_eng_feeder

Overview:
- Initiator side of the PE data-in stream (DIN_VLD/DIN_RDY, ACT_*/WEI_*).
- On START, reads a run of activations from ARAM, a synchronous RAM with 1-cycle read latency.
- For each activation it emits one beat per active weight index, pairing the activation with weights from an internal weight register file.
- Optional zero-weight skipping; marks WEI_LST per activation and ACT_LST on the final activation, so the downstream PE can detect end of stream.

Parameters:
DATA_ACT_DW 8 activation width
DATA_WEI_DW 8 weight width
ARAM_ADD_AW 10 ARAM address / activation index width
CONV_WEI_DW 3 weight index width; register file depth 2**CONV_WEI_DW

Ports:
clk in 1 clock
rst_n in 1 reset, asynchronous, active-low
START in 1 start pulse; honoured only in IDLE
BUSY out 1 high in any state except IDLE
DONE out 1 one-cycle pulse after final handshake
CFG_ACT_BASE in ARAM_ADD_AW ARAM address of activation 0
CFG_ACT_LEN in ARAM_ADD_AW+1 activation count
CFG_WEI_LEN in CONV_WEI_DW kernel length
CFG_SKIP_ZERO in 1 skip zero weights at index>0
WEI_WEN in 1 weight write strobe
WEI_WADD in CONV_WEI_DW weight write index
WEI_WDAT in DATA_WEI_DW weight write data
ARAM_REN out 1 ARAM read enable
ARAM_RADD out ARAM_ADD_AW ARAM read address
ARAM_RDAT in DATA_ACT_DW ARAM read data, valid the cycle after ARAM_REN
DIN_VLD out 1 beat valid
DIN_RDY in 1 downstream ready
ACT_LST out 1 beat belongs to last activation
WEI_LST out 1 last beat of current activation
ACT_DAT out DATA_ACT_DW activation value
ACT_ADD out ARAM_ADD_AW activation index, 0-based, relative to base
WEI_DAT out DATA_WEI_DW weight value
WEI_IDX out CONV_WEI_DW weight index

Behaviour:
- Reset: every output is 0. State is IDLE. Counters, act register and weight file are cleared.
- Weight file writes occur only when WEI_WEN is high in IDLE; writes while BUSY are dropped.
- START sampling (in IDLE):
  - Latch base, len, skip.
  - Effective wei_len = max(CFG_WEI_LEN,1).
  - Build nz_mask: bit k = (k<wei_len) && (k==0 || !skip || w[k]!=0). Index 0 is always emitted.
  - last_idx = highest set bit of nz_mask.
- START in other states is ignored. Config changes after START have no effect.
- FSM states and transitions:
  - IDLE: on START, go to DONE if len==0, else go to RD.
  - RD: ARAM_REN=1, ARAM_RADD=base+act_cnt (mod 2**ARAM_ADD_AW). Always → WAIT.
  - WAIT: latch ARAM_RDAT into act_reg; wei_cnt = 0. → EMIT.
  - EMIT: on a handshake (DIN_VLD&&DIN_RDY):
    - if wei_cnt==last_idx: if act_cnt==len-1 → DONE; else act_cnt+1 → RD.
    - otherwise wei_cnt = next set bit of nz_mask above wei_cnt (combinational priority search).
  - DONE: DONE=1 for one cycle → IDLE.
- Beat outputs in EMIT:
  - DIN_VLD=1 only in EMIT.
  - ACT_DAT=act_reg, ACT_ADD=act_cnt, WEI_IDX=wei_cnt, WEI_DAT=w[wei_cnt].
  - WEI_LST=(wei_cnt==last_idx); ACT_LST=(act_cnt==len-1).
  - All beat outputs are 0 outside EMIT.
- Handshake: while DIN_VLD && !DIN_RDY, every beat output holds stable. DIN_VLD never drops without a handshake.
- Latency: START at cycle 0 → ARAM_REN at cycle 1 → first DIN_VLD at cycle 3.
  - Each activation costs 2 + nnz cycles at full ready (nnz = popcount of nz_mask).
  - DONE is asserted the cycle after the final handshake.
- ACT_ADD sequence is strictly increasing by 1 from 0; it never wraps, because len ≤ 2**ARAM_ADD_AW. ARAM_RADD wraps modulo the RAM size.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Weight contents are cleared and must be reloaded.

Test Plan:
1. Weights [3,0,-2], wei_len=3, skip=1, base=4, ARAM[4]=5, ARAM[5]=-1, len=2, DIN_RDY=1 →
   - beats (5,add0,3,idx0), (5,0,-2,idx2,WEI_LST), (-1,1,3,0), (-1,1,-2,2,WEI_LST+ACT_LST);
   - ARAM_RADD 4 then 5; DONE one cycle after last beat.
2. Same as 1 with skip=0 → 6 beats per order idx0,1,2; idx1 carries WEI_DAT=0; WEI_LST on idx2 only.
3. Case 1 with DIN_RDY low for 3 cycles on the 2nd beat → outputs frozen bit-exact during the stall; 4 beats total, no duplicate or missing beats.
4. len=0 → DONE the cycle after START, no DIN_VLD, no ARAM_REN. All weights zero with skip=1, wei_len=5, len=1 → single beat idx0 with WEI_LST+ACT_LST.
5. Assert rst_n low during EMIT → all outputs 0 the same cycle; after reload, a fresh START reproduces scenario 1.
6. WEI_WEN during BUSY changes nothing in the beat stream; START during BUSY is ignored (the DONE count stays 1).
